serial_subtractor_ctrl: RTL and testbench

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_subtractor_ctrl_pkg.sv | 18 +
 rtl/subtractor.sv | 14 +
 rtl/serial_subtractor_ctrl.sv | 100 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the default operand width.
package serial_subtractor_ctrl_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width able to hold 0..w without wrapping.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/subtractor.sv
// 1-bit full-subtractor cell: D = a - b - Bin, with borrow out.
// Purely combinational; shared by every bit of a serial operation.
module subtractor (
   input  logic a,
   input  logic b,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = a ^ b ^ Bin;
   assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first,
// one bit per clock, sequenced by an IDLE/RUN/DONE FSM.
module serial_subtractor_ctrl
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cell_d;
   logic             cell_bout;

   // Operand registers shift right so bit i always sits at position 0.
   subtractor u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .Bin  (brw_q),
      .D    (cell_d),
      .Bout (cell_bout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               brw_d   = borrow_in;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            diff_d = {cell_d, diff_q[WIDTH-1:1]};
            brw_d  = cell_bout;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = brw_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8),
// scoreboard of expected {borrow_out, diff} per accepted start.
module tb_serial_subtractor_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int vectors     = 0;
   int miscompares = 0;

   logic [W:0] sb[$];

   always #5 clk = ~clk;

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (bin),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (bout)
   );

   function automatic logic [W:0] model(
      input logic [W-1:0] x,
      input logic [W-1:0] y,
      input logic         bi
   );
      logic [W:0] r;
      r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'hA5;
      b     = 8'h5A;
      bin   = 1'b1;
      step();
      step();
      vectors++;
      if ({busy, done} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_ctl got busy/done=%b want 00",
                  {busy, done});
      end
      vectors++;
      if ({bout, diff} !== 9'h000) begin
         miscompares++;
         $display("FAIL reset_data got %h want 000", {bout, diff});
      end
      rst = 1'b0;
   endtask

   task automatic run_op(
      input logic [W-1:0] x,
      input logic [W-1:0] y,
      input logic         bi
   );
      logic [W:0] exp;
      int dn;
      int bcnt;
      a     = x;
      b     = y;
      bin   = bi;
      start = 1'b1;
      sb.push_back(model(x, y, bi));
      step();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      dn    = 0;
      bcnt  = (busy === 1'b1) ? 1 : 0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (busy === 1'b1) bcnt++;
         if (done === 1'b1) begin
            dn = n;
            break;
         end
      end
      exp = sb.pop_front();
      vectors++;
      if (dn != W) begin
         miscompares++;
         $display("FAIL latency got %0d want %0d", dn, W);
      end
      vectors++;
      if (bcnt != W + 1) begin
         miscompares++;
         $display("FAIL busy_len got %0d want %0d", bcnt, W + 1);
      end
      vectors++;
      if ({bout, diff} !== exp) begin
         miscompares++;
         $display("FAIL result %h-%h-%b got %h want %h",
                  x, y, bi, {bout, diff}, exp);
      end
      step();
      vectors++;
      if ({busy, done} !== 2'b00 || {bout, diff} !== exp) begin
         miscompares++;
         $display("FAIL post_done got %b/%h want 00/%h",
                  {busy, done}, {bout, diff}, exp);
      end
   endtask

   task automatic test_vectors();
      run_op(8'd5, 8'd3, 1'b0);
      run_op(8'd3, 8'd5, 1'b0);
      run_op(8'h00, 8'h00, 1'b1);
      run_op(8'hFF, 8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_ignore_start();
      logic [W:0] exp;
      logic [W:0] got;
      int ndone;
      a     = 8'h37;
      b     = 8'h12;
      bin   = 1'b1;
      start = 1'b1;
      sb.push_back(model(8'h37, 8'h12, 1'b1));
      step();
      start = 1'b0;
      step();
      step();
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h55;
      step();
      start = 1'b0;
      a     = 8'hC3;
      ndone = 0;
      got   = '0;
      for (int n = 0; n < 25; n++) begin
         step();
         if (done === 1'b1) begin
            if (ndone == 0) got = {bout, diff};
            ndone++;
         end
      end
      exp = sb.pop_front();
      vectors++;
      if (ndone != 1) begin
         miscompares++;
         $display("FAIL ignore_cnt got %0d dones want 1", ndone);
      end
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL ignore_res got %h want %h", got, exp);
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      a     = 8'hAA;
      b     = 8'h0F;
      bin   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if ({busy, done, bout, diff} !== 11'h000) begin
         miscompares++;
         $display("FAIL abort got %b/%h want 00/000",
                  {busy, done}, {bout, diff});
      end
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done === 1'b1) ndone++;
      end
      vectors++;
      if (ndone != 0) begin
         miscompares++;
         $display("FAIL abort_done got %0d want 0", ndone);
      end
      run_op(8'd9, 8'd4, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [W:0] exp;
      int t;
      int last;
      int nd;
      t     = 0;
      last  = -1;
      nd    = 0;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      start = 1'b1;
      sb.push_back(model(a, b, bin));
      step();
      for (int n = 1; n <= 45; n++) begin
         if (n == 31) start = 1'b0;
         step();
         t++;
         if (done === 1'b1) begin
            nd++;
            exp = sb.pop_front();
            vectors++;
            if ({bout, diff} !== exp) begin
               miscompares++;
               $display("FAIL b2b_res got %h want %h",
                        {bout, diff}, exp);
            end
            if (last >= 0) begin
               vectors++;
               if (t - last != W + 2) begin
                  miscompares++;
                  $display("FAIL b2b_period got %0d want %0d",
                           t - last, W + 2);
               end
            end
            last = t;
            if (start === 1'b1) begin
               a   = W'($urandom);
               b   = W'($urandom);
               bin = 1'($urandom);
               sb.push_back(model(a, b, bin));
            end
         end
      end
      vectors++;
      if (nd != 4 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_count got %0d dones/%0d left want 4/0",
                  nd, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
